max_comparator: RTL

MAX_COMPARATOR -- requirements
Module: max_comparator

---
 rtl/max_comparator.sv | 103 ++++++++++
 1 files changed

// File: rtl/max_comparator.sv
// Running-maximum tracker for a calibration sweep: discards SETTLE strobes, then records
// each sample that beats the stored maximum by more than HYST and pulses CNT_RST one cycle later.
module max_comparator #(
    parameter int DATA_W = 12,
    parameter int HYST   = 4,
    parameter int SETTLE = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CAL_EN,
    input  logic              ADC_VALID,
    input  logic [DATA_W-1:0] ADC_DATA,
    output logic              CNT_RST,
    output logic [DATA_W-1:0] MAX_VAL,
    output logic              MAX_VALID
);

    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_TRACK  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic                max_vld_q, max_vld_d;
    logic                cnt_rst_q, cnt_rst_d;

    // Threshold is one bit wider than the data so it cannot wrap; a maximum near full
    // scale therefore pushes the threshold out of reach of any sample.
    logic [DATA_W:0]     threshold;
    logic                beats_max;

    assign threshold = {1'b0, max_q} + (DATA_W + 1)'(HYST);
    assign beats_max = ({1'b0, ADC_DATA} > threshold);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        max_d        = max_q;
        max_vld_d    = max_vld_q;
        cnt_rst_d    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HOLD: begin
                if (CAL_EN) begin
                    max_d        = '0;
                    max_vld_d    = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!CAL_EN) begin
                    state_d = S_HOLD;
                end else if (SETTLE == 0) begin
                    state_d = S_TRACK;
                end else if (ADC_VALID) begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                    if (settle_cnt_d == CNT_W'(SETTLE)) begin
                        state_d = S_TRACK;
                    end
                end
            end
            S_TRACK: begin
                if (!CAL_EN) begin
                    state_d = S_HOLD;
                end else if (ADC_VALID && (!max_vld_q || beats_max)) begin
                    // An empty maximum accepts anything, including zero.
                    max_d     = ADC_DATA;
                    max_vld_d = 1'b1;
                    cnt_rst_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            max_q        <= '0;
            max_vld_q    <= 1'b0;
            cnt_rst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            max_q        <= max_d;
            max_vld_q    <= max_vld_d;
            cnt_rst_q    <= cnt_rst_d;
        end
    end

    assign CNT_RST   = cnt_rst_q;
    assign MAX_VAL   = max_q;
    assign MAX_VALID = max_vld_q;

endmodule
